// File: rtl/wb_mem_bridge.sv
// wb_mem_bridge: Wishbone slave address window bridged onto a picorv32-style native memory bus.
// One transfer at a time; a stuck native slave is abandoned after TIMEOUT request cycles.
module wb_mem_bridge #(
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFF00_0000,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        mem_valid_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic        timeout_o,
   input  logic        timeout_clr_i,
   output logic        busy_o
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ack_q, ack_d;
   logic [31:0]   rdat_q, rdat_d;
   logic          valid_q, valid_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          we_q, we_d;
   logic          to_q, to_d;
   logic          live, hit, expire, to_set;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         we_q    <= we_d;
         to_q    <= to_d;
      end
   end
   always_comb begin
      live    = wbs_cyc_i & wbs_stb_i;
      hit     = live & ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
      expire  = (cnt_q == CW'(TIMEOUT - 1));
      to_set  = (state_q == REQ) & ~mem_ready_i & expire;
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      rdat_d  = rdat_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      we_d    = we_q;
      case (state_q)
         IDLE: if (hit) begin
            state_d = REQ;
            cnt_d   = '0;
            valid_d = 1'b1;
            addr_d  = wbs_adr_i & ~ADDR_MASK;
            wdata_d = wbs_dat_i;
            wstrb_d = wbs_we_i ? wbs_sel_i : 4'b0000;
            we_d    = wbs_we_i;
         end
         // ready has priority over an expiring counter in the same cycle
         REQ: if (mem_ready_i || expire) begin
            state_d = ACK;
            valid_d = 1'b0;
            ack_d   = live;
            rdat_d  = mem_ready_i ? (we_q ? 32'h0 : mem_rdata_i) : 32'hDEAD_BEEF;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      to_d = to_set ? 1'b1 : timeout_clr_i ? 1'b0 : to_q;
   end
   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = rdat_q;
   assign mem_valid_o = valid_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wstrb_o = wstrb_q;
   assign timeout_o   = to_q;
   assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_wb_mem_bridge.sv
// tb_wb_mem_bridge: table-driven, hand-sequenced and randomized checks of wb_mem_bridge
// against a transaction-level model of the bridge's observable behaviour.
module tb_wb_mem_bridge;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] MASK = 32'hFF00_0000;
   localparam int TO = 255;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ready = 1'b0, clr = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0, wdat = '0, rdata = '0;
   logic        ack, valid, to, busy;
   logic [31:0] dat_o, maddr, mwdata;
   logic [3:0]  mwstrb;

   always #5 clk = ~clk;

   wb_mem_bridge #(.ADDR_BASE(BASE), .ADDR_MASK(MASK), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .mem_valid_o(valid), .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_wstrb_o(mwstrb),
      .mem_ready_i(ready), .mem_rdata_i(rdata),
      .timeout_o(to), .timeout_clr_i(clr), .busy_o(busy)
   );

   typedef struct {
      logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; logic [31:0] rdata;
      int w; int abort_at; bit hold; bit b2b;
      int e_nvalid; bit e_ack; int e_ack_at; logic [31:0] e_dat; logic [31:0] e_addr;
      logic [3:0] e_wstrb; logic [31:0] e_wdata; bit e_to; int e_busy;
   } vec_t;

   int n_chk = 0, n_fail = 0;
   int o_nvalid, o_ack_cnt, o_ack_at, o_busy;
   logic [31:0] o_dat, o_addr, o_wdata;
   logic [3:0] o_wstrb;
   logic o_to;
   bit o_stable;
   logic [31:0] last_dat;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic w_e, input logic [3:0] s,
                               input logic [31:0] d, input logic [31:0] rd, input int wt, input int ab,
                               input int nv, input bit ak, input int ak_at, input logic [31:0] ed,
                               input logic [31:0] ea, input logic [3:0] es, input bit et, input int eb);
      vec_t v;
      v.adr = a; v.we = w_e; v.sel = s; v.dat = d; v.rdata = rd; v.w = wt; v.abort_at = ab;
      v.hold = 0; v.b2b = 0;
      v.e_nvalid = nv; v.e_ack = ak; v.e_ack_at = ak_at; v.e_dat = ed; v.e_addr = ea;
      v.e_wstrb = es; v.e_wdata = d; v.e_to = et; v.e_busy = eb;
      return v;
   endfunction

   // Transaction-level reference: ready offered after w wait cycles wins unless the
   // TO-cycle request window has already run out.
   function automatic vec_t model(input vec_t v, input logic [31:0] prev);
      vec_t r = v;
      int fin;
      if ((v.adr & MASK) != BASE) begin
         r.e_nvalid = 0; r.e_ack = 0; r.e_ack_at = 0; r.e_dat = prev; r.e_to = 0; r.e_busy = 0;
         r.e_addr = 0; r.e_wstrb = 0; r.e_wdata = 0;
      end else begin
         fin = (v.w < TO) ? v.w + 1 : TO;
         r.e_nvalid = fin; r.e_busy = fin + 1; r.e_ack = (v.abort_at == 0); r.e_ack_at = fin + 1;
         r.e_dat = (v.w < TO) ? (v.we ? 32'h0 : v.rdata) : 32'hDEAD_BEEF;
         r.e_to = (v.w >= TO);
         r.e_addr = v.adr & ~MASK; r.e_wstrb = v.we ? v.sel : 4'h0; r.e_wdata = v.dat;
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v);
      bit started = 0, done = 0;
      if (!v.b2b) begin
         cyc = 0; stb = 0;
         @(negedge clk);
         chk("idle.busy", 32'(busy), 0);
         chk("idle.ack", 32'(ack), 0);
      end
      cyc = 1; stb = 1; we = v.we; sel = v.sel; adr = v.adr; wdat = v.dat;
      if (v.b2b) begin
         @(negedge clk);
         chk("b2b_gap.busy", 32'(busy), 0);
      end
      o_nvalid = 0; o_ack_cnt = 0; o_ack_at = 0; o_busy = 0; o_stable = 1;
      o_dat = 'x; o_to = 1'bx; o_addr = 'x; o_wdata = 'x; o_wstrb = 'x;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (busy) o_busy++;
         if (ack) begin o_ack_cnt++; o_ack_at = c; end
         if (valid) begin
            started = 1;
            o_nvalid++;
            if (o_nvalid == 1) begin
               o_addr = maddr; o_wdata = mwdata; o_wstrb = mwstrb;
            end else if (maddr !== o_addr || mwdata !== o_wdata || mwstrb !== o_wstrb) o_stable = 0;
            ready = (o_nvalid == v.w + 1);
            rdata = ready ? v.rdata : $urandom;
            if (o_nvalid == v.abort_at) begin cyc = 0; stb = 0; end
         end else begin
            ready = 0; rdata = $urandom;
            if (started) begin o_dat = dat_o; o_to = to; done = 1; end
            else if (c >= 20) done = 1;
         end
         if (done) break;
      end
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL txn_bound: transfer at %h still open after 300 cycles", v.adr);
      end
      if (!v.hold) begin cyc = 0; stb = 0; end
   endtask

   task automatic apply(input vec_t v, input string tag);
      run_txn(v);
      chk({tag, ".nvalid"}, o_nvalid, v.e_nvalid);
      chk({tag, ".acks"}, o_ack_cnt, 32'(v.e_ack));
      if (v.e_ack) chk({tag, ".ack_at"}, o_ack_at, v.e_ack_at);
      chk({tag, ".busy"}, o_busy, v.e_busy);
      if (v.e_nvalid > 0) begin
         chk({tag, ".dat"}, o_dat, v.e_dat);
         chk({tag, ".to"}, 32'(o_to), 32'(v.e_to));
         chk({tag, ".addr"}, o_addr, v.e_addr);
         chk({tag, ".wstrb"}, 32'(o_wstrb), 32'(v.e_wstrb));
         chk({tag, ".wdata"}, o_wdata, v.e_wdata);
         chk({tag, ".stable"}, 32'(o_stable), 1);
      end else begin
         chk({tag, ".dat_hold"}, dat_o, v.e_dat);
      end
      last_dat = v.e_dat;
      if (!v.hold) begin
         clr = 1;
         @(negedge clk);
         clr = 0;
         chk({tag, ".to_clr"}, 32'(to), 0);
      end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int acks, busys;
      tbl[0] = mk(32'h3000_0010, 0, 4'hF, 32'h0, 32'h1234_5678, 0, 0, 1, 1, 2, 32'h1234_5678, 32'h10, 4'h0, 0, 2);
      tbl[1] = mk(32'h3000_0004, 1, 4'h6, 32'hAABB_CCDD, 32'h5555_5555, 3, 0, 4, 1, 5, 32'h0, 32'h4, 4'h6, 0, 5);
      tbl[2] = mk(32'h2000_0000, 0, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
      tbl[3] = mk(32'h3000_0000, 0, 4'hF, 32'h0, 32'h1111_1111, 999, 0, 255, 1, 256, 32'hDEAD_BEEF, 32'h0, 4'h0, 1, 256);
      tbl[4] = mk(32'h30AB_CDEC, 0, 4'hF, 32'h0, 32'hCAFE_F00D, 254, 0, 255, 1, 256, 32'hCAFE_F00D, 32'h00AB_CDEC, 4'h0, 0, 256);
      tbl[5] = mk(32'h3000_0020, 0, 4'hF, 32'h0, 32'h0BAD_F00D, 2, 1, 3, 0, 0, 32'h0BAD_F00D, 32'h20, 4'h0, 0, 4);
      tbl[6] = mk(32'h30FF_FFFC, 0, 4'hF, 32'h0, 32'h8765_4321, 1, 0, 2, 1, 3, 32'h8765_4321, 32'h00FF_FFFC, 4'h0, 0, 3);
      tbl[7] = mk(32'h3000_0100, 1, 4'hF, 32'h0102_0304, 32'hFFFF_FFFF, 0, 0, 1, 1, 2, 32'h0, 32'h100, 4'hF, 0, 2);
      tbl[8] = mk(32'h4000_0100, 0, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);

      repeat (2) @(negedge clk);
      chk("rst.ack", 32'(ack), 0);
      chk("rst.dat", dat_o, 0);
      chk("rst.valid", 32'(valid), 0);
      chk("rst.addr", maddr, 0);
      chk("rst.wdata", mwdata, 0);
      chk("rst.wstrb", 32'(mwstrb), 0);
      chk("rst.to", 32'(to), 0);
      chk("rst.busy", 32'(busy), 0);
      rst = 0;
      last_dat = 0;

      foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

      v = mk(32'h3000_0200, 0, 4'hF, 32'h0, 32'h1357_2468, 0, 0, 1, 1, 2, 32'h1357_2468, 32'h200, 4'h0, 0, 2);
      v.hold = 1;
      apply(v, "b2b_a");
      v = mk(32'h3000_0204, 1, 4'h3, 32'h9988_7766, 32'h2222_2222, 1, 0, 2, 1, 3, 32'h0, 32'h204, 4'h3, 0, 3);
      v.b2b = 1;
      apply(v, "b2b_b");

      clr = 1;
      v = mk(32'h3000_0300, 0, 4'hF, 32'h0, 32'h3333_3333, 999, 0, 255, 1, 256, 32'hDEAD_BEEF, 32'h300, 4'h0, 1, 256);
      apply(v, "set_vs_clr");

      @(negedge clk);
      cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0040; ready = 0;
      @(negedge clk);
      chk("rst_mid.valid_before", 32'(valid), 1);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("rst_mid.valid", 32'(valid), 0);
      chk("rst_mid.busy", 32'(busy), 0);
      chk("rst_mid.addr", maddr, 0);
      cyc = 0; stb = 0;
      @(negedge clk);
      rst = 0;
      acks = 0; busys = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack) acks++;
         if (busy) busys++;
      end
      chk("rst_mid.no_ack", acks, 0);
      chk("rst_mid.no_busy", busys, 0);
      last_dat = 0;
      apply(mk(32'h3000_0044, 0, 4'hF, 32'h0, 32'h4444_4444, 0, 0, 1, 1, 2, 32'h4444_4444, 32'h44, 4'h0, 0, 2), "after_rst");

      for (int i = 0; i < 40; i++) begin
         logic [7:0] top;
         v.adr = $urandom; v.we = 1'($urandom); v.sel = 4'($urandom); v.dat = $urandom;
         v.rdata = $urandom; v.w = $urandom_range(0, 6); v.abort_at = 0; v.hold = 0; v.b2b = 0;
         if ($urandom_range(0, 3) != 0) v.adr[31:24] = BASE[31:24];
         else begin
            top = 8'($urandom);
            if (top == BASE[31:24]) top = top + 8'd1;
            v.adr[31:24] = top;
         end
         if ($urandom_range(0, 14) == 0) v.w = $urandom_range(TO - 1, TO + 2);
         else if ($urandom_range(0, 5) == 0) v.abort_at = 1 + $urandom_range(0, v.w);
         v = model(v, last_dat);
         apply(v, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
